// File: rtl/div_unit.sv
// 32-bit restoring divider (signed/unsigned), one quotient bit per cycle.
// Optional macro DIV_UNIT_FAST_SPECIAL_EN: divide-by-zero and signed overflow finish in one cycle.
module div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  ctrl,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done,
  output logic [1:0]  state_dbg
);

  // Handshake: a request is taken on a rising edge with in_valid && in_ready;
  // in_ready is high only in IDLE, and nothing presented outside IDLE is queued.
  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, FIN = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] acc_q, acc_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] dvd_q, dvd_d;
  logic        neg_q_q, neg_q_d;
  logic        neg_r_q, neg_r_d;
  logic        div0_q, div0_d;
  logic        ovf_q, ovf_d;
  logic [31:0] quotient_q, quotient_d;
  logic [31:0] remainder_q, remainder_d;
  logic        done_q, done_d;

  logic        unused_ctrl_bit1;
  logic        signed_op, a_neg, b_neg, in_div0, in_ovf;
  logic [31:0] a_mag, b_mag;
  logic [32:0] shifted, acc_n;
  logic        ge;
  logic [31:0] quo_n, q_fix, r_fix;

  assign unused_ctrl_bit1 = ctrl[1];

  assign in_ready  = (state_q == IDLE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign done      = done_q;
  assign state_dbg = state_q;

  always_comb begin
    signed_op = ~ctrl[0];
    a_neg     = signed_op & dividend[31];
    b_neg     = signed_op & divisor[31];
    a_mag     = a_neg ? (32'd0 - dividend) : dividend;
    b_mag     = b_neg ? (32'd0 - divisor) : divisor;
    in_div0   = (divisor == 32'd0);
    in_ovf    = signed_op && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    shifted = {acc_q[31:0], quo_q[31]};
    ge      = (shifted >= {1'b0, dvs_q});
    acc_n   = ge ? (shifted - {1'b0, dvs_q}) : shifted;
    quo_n   = {quo_q[30:0], ge};
    q_fix   = neg_q_q ? (32'd0 - quo_n) : quo_n;
    r_fix   = neg_r_q ? (32'd0 - acc_n[31:0]) : acc_n[31:0];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    dvd_d       = dvd_q;
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    div0_d      = div0_q;
    ovf_d       = ovf_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          cnt_d   = 5'd0;
          acc_d   = 33'd0;
          quo_d   = a_mag;
          dvs_d   = b_mag;
          dvd_d   = dividend;
          neg_q_d = a_neg ^ b_neg;
          neg_r_d = a_neg;
          div0_d  = in_div0;
          ovf_d   = in_ovf;
`ifdef DIV_UNIT_FAST_SPECIAL_EN
          if (in_div0 || in_ovf) begin
            state_d     = FIN;
            done_d      = 1'b1;
            quotient_d  = in_div0 ? 32'hFFFF_FFFF : 32'h8000_0000;
            remainder_d = in_div0 ? dividend : 32'd0;
          end else begin
            state_d = ITER;
          end
`else
          state_d = ITER;
`endif
        end
      end
      ITER: begin
        acc_d = acc_n;
        quo_d = quo_n;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = FIN;
          done_d  = 1'b1;
          // Special cases override the iterated result so both builds agree.
          if (div0_q) begin
            quotient_d  = 32'hFFFF_FFFF;
            remainder_d = dvd_q;
          end else if (ovf_q) begin
            quotient_d  = 32'h8000_0000;
            remainder_d = 32'd0;
          end else begin
            quotient_d  = q_fix;
            remainder_d = r_fix;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      acc_q       <= 33'd0;
      quo_q       <= 32'd0;
      dvs_q       <= 32'd0;
      dvd_q       <= 32'd0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      div0_q      <= 1'b0;
      ovf_q       <= 1'b0;
      quotient_q  <= 32'd0;
      remainder_q <= 32'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      dvd_q       <= dvd_d;
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
      div0_q      <= div0_d;
      ovf_q       <= ovf_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
    end
  end

endmodule
